// File: rtl/lod_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lod_arb_pkg
//  Description : Shared types and helpers for the leading-one-detect
//                round-robin arbiter (state encoding, clog2, mod-N decrement).
//  Revision    : 1.0 - initial release
// ============================================================================
package lod_arb_pkg;

  // Arbiter state machine encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions (parameter derivation).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

  // (value - 1) mod modulus, for value in 0..modulus-1.
  function automatic int unsigned dec_mod(input int unsigned value,
                                          input int unsigned modulus);
    return (value == 0) ? (modulus - 1) : (value - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lod_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : lod_rr_pick
//  Description : Combinational round-robin winner selection. The request
//                vector is rotated so that req[ptr] sits at the MSB, padded
//                with zeros at the LSBs to a power-of-two width, and a
//                leading-zero count gives the distance from ptr to the winner.
//  Revision    : 1.0 - initial release
//  Ports       :
//    req    in  N  request vector
//    ptr    in  S  highest-priority index
//    winner out S  selected index, (ptr - lzc) mod N
//    any    out 1  at least one request is active
// ============================================================================
module lod_rr_pick
  import lod_arb_pkg::*;
#(
  parameter  int N = 8,
  localparam int S = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [S-1:0] ptr,
  output logic [S-1:0] winner,
  output logic         any
);

  localparam int         P     = 1 << S;
  localparam logic [S:0] N_EXT = (S+1)'(N);

  logic [N-1:0] w_rot;
  logic [P-1:0] w_pad;
  logic [S-1:0] w_lz;
  logic         w_found;
  logic [S:0]   w_ptr_ext;
  logic [S:0]   w_lz_ext;

  // {req,req} shifted right by ptr+1 leaves req[ptr] at bit N-1, req[ptr-1]
  // at bit N-2, and so on around the ring.
  assign w_rot = N'({req, req} >> ({1'b0, ptr} + 1'b1));

  // Pad bits are zero so they can never be detected as the leading one.
  if (P > N) begin : g_pad
    assign w_pad = {w_rot, {(P-N){1'b0}}};
  end else begin : g_no_pad
    assign w_pad = w_rot;
  end

  // Leading-zero count from the MSB of the padded vector.
  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int k = 0; k < P; k++) begin
      if (!w_found) begin
        if (w_pad[P-1-k]) begin
          w_found = 1'b1;
        end else begin
          w_lz = w_lz + 1'b1;
        end
      end
    end
  end

  assign w_ptr_ext = {1'b0, ptr};
  assign w_lz_ext  = {1'b0, w_lz};

  // With any request present the count is below N, so one wrap suffices.
  assign winner = S'((w_ptr_ext >= w_lz_ext) ? (w_ptr_ext - w_lz_ext)
                                             : (w_ptr_ext + N_EXT - w_lz_ext));
  assign any    = w_found;

endmodule
`default_nettype wire

// File: rtl/lod_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lod_rr_arbiter
//  Description : Round-robin arbiter sharing one downstream resource among N
//                requesters. A grant is offered (gnt_vld) until the resource
//                accepts it (res_ready) and is held until done. Priority
//                moves to just below the last owner after each transaction.
//  Revision    : 1.0 - initial release
//  Config      : LOD_ARB_TIMEOUT_EN - enables the BUSY watchdog that forces
//                release after TIMEOUT cycles and pulses err.
//  Ports       :
//    clk       in  1  clock, rising edge
//    rst       in  1  asynchronous reset, active-high
//    req       in  N  request levels
//    gnt       out N  one-hot owner, held through GRANT and BUSY
//    gnt_idx   out S  binary owner index
//    gnt_vld   out 1  grant offered (GRANT state only)
//    res_ready in  1  resource accepts the offered grant
//    done      in  1  resource finished the owner's operation
//    err       out 1  one-cycle timeout pulse
// ============================================================================
module lod_rr_arbiter
  import lod_arb_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int TIMEOUT = 255,
  localparam int S       = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [S-1:0] gnt_idx,
  output logic         gnt_vld,
  input  logic         res_ready,
  input  logic         done,
  output logic         err
);

  state_t       r_state;
  state_t       w_state_next;
  logic [S-1:0] r_ptr;
  logic [N-1:0] r_gnt;
  logic [S-1:0] r_gnt_idx;
  logic         r_err;

  logic [S-1:0] w_winner;
  logic         w_any;
  logic [N-1:0] w_onehot;
  logic         w_load;
  logic         w_release;
  logic         w_err_next;
  logic         w_timeout;

  lod_rr_pick #(
    .N (N)
  ) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_winner;

`ifdef LOD_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT + 1);

  logic [CW-1:0] r_busy_cnt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_busy_cnt + 1'b1;
  // Fires in the BUSY cycle whose increment reaches TIMEOUT.
  assign w_timeout = (r_state == BUSY) && (w_cnt_inc == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_cnt <= '0;
    end else if (r_state == GRANT) begin
      // Cleared while offering, so it starts from zero on entry to BUSY.
      r_busy_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_busy_cnt <= w_cnt_inc;
    end
  end
`else
  assign w_timeout = 1'b0;

  // TIMEOUT has no effect in this build; kept referenced for parameter checks.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // Next-state and transaction strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_release    = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = GRANT;
          w_load       = 1'b1;
        end
      end
      GRANT: begin
        // The grant is committed: req changes are ignored here.
        if (res_ready) begin
          if (done) begin
            w_state_next = IDLE;
            w_release    = 1'b1;
          end else begin
            w_state_next = BUSY;
          end
        end
      end
      BUSY: begin
        // done takes precedence over a coincident timeout.
        if (done) begin
          w_state_next = IDLE;
          w_release    = 1'b1;
        end else if (w_timeout) begin
          w_state_next = IDLE;
          w_release    = 1'b1;
          w_err_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= S'(N - 1);
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (w_load) begin
        r_gnt     <= w_onehot;
        r_gnt_idx <= w_winner;
      end else if (w_release) begin
        r_gnt     <= '0;
        r_gnt_idx <= '0;
        // Owner drops to lowest priority; the one below it becomes highest.
        r_ptr     <= S'(dec_mod(32'(r_gnt_idx), 32'(N)));
      end
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign gnt_vld = (r_state == GRANT);
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lod_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lod_rr_arbiter
//  Description : Self-checking bench for lod_rr_arbiter (N=8, TIMEOUT=4).
//                Table of {inputs, expected outputs} per clock plus
//                hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lod_rr_arbiter;

  localparam int N       = 8;
  localparam int TIMEOUT = 4;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] req       = 8'h00;
  logic       res_ready = 1'b0;
  logic       done      = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       err;

  int tests_run    = 0;
  int tests_failed = 0;

  lod_rr_arbiter #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld),
    .res_ready (res_ready),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] v_req;
    logic       v_rr;
    logic       v_dn;
    logic [7:0] e_gnt;
    logic [2:0] e_idx;
    logic       e_vld;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] r, input logic rr, input logic dn,
                              input logic [7:0] eg, input logic [2:0] ei, input logic ev);
    vec_t v;
    v.v_req = r;
    v.v_rr  = rr;
    v.v_dn  = dn;
    v.e_gnt = eg;
    v.e_idx = ei;
    v.e_vld = ev;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic ee);
    tests_run++;
    if (gnt !== eg || gnt_idx !== ei || gnt_vld !== ev || err !== ee) begin
      tests_failed++;
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b err=%b, expected gnt=%h idx=%0d vld=%b err=%b",
               name, gnt, gnt_idx, gnt_vld, err, eg, ei, ev, ee);
    end
  endtask

  // Drive inputs for one cycle, then land 1 time unit after the next edge.
  task automatic apply(input logic [7:0] r, input logic rr, input logic dn);
    req       = r;
    res_ready = rr;
    done      = dn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    logic [2:0] id;
    logic [7:0] oh;

    // ---- table: first grant after reset, back-to-back fairness, full rotation
    tbl.push_back(mk(8'h01, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1)); // first grant, idx 0
    tbl.push_back(mk(8'h00, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0)); // single-cycle op, vld 1 cycle
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0)); // idle with no req
    tbl.push_back(mk(8'h81, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1)); // ptr=7 -> idx 7
    tbl.push_back(mk(8'h81, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0));
    tbl.push_back(mk(8'h81, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1)); // idx 0 next, not 7 again
    tbl.push_back(mk(8'h81, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0));
    for (int k = 0; k < 9; k++) begin
      id = 3'(7 - k);                                        // 7,6,...,0,7
      oh = 8'h01 << id;
      tbl.push_back(mk(8'hFF, 1'b0, 1'b0, oh,    id,   1'b1));
      tbl.push_back(mk(8'hFF, 1'b1, 1'b0, oh,    id,   1'b0));
      tbl.push_back(mk(8'hFF, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0));
    end

    // ---- reset held with random requests
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      req = 8'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    end
    req = 8'h00;
    rst = 1'b0;

    // ---- table-driven vectors
    foreach (tbl[i]) begin
      apply(tbl[i].v_req, tbl[i].v_rr, tbl[i].v_dn);
      check($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_idx, tbl[i].e_vld, 1'b0);
    end
    // ptr is now 6

    // ---- request drop during GRANT is ignored; ptr becomes 2
    apply(8'h08, 1'b0, 1'b0); check("drop_grant",     8'h08, 3'd3, 1'b1, 1'b0);
    apply(8'h00, 1'b0, 1'b0); check("drop_held",      8'h08, 3'd3, 1'b1, 1'b0);
    apply(8'h00, 1'b1, 1'b0); check("drop_busy",      8'h08, 3'd3, 1'b0, 1'b0);
    apply(8'h00, 1'b1, 1'b0); check("rr_in_busy",     8'h08, 3'd3, 1'b0, 1'b0);
    apply(8'h00, 1'b0, 1'b1); check("drop_done",      8'h00, 3'd0, 1'b0, 1'b0);
    apply(8'h00, 1'b0, 1'b1); check("done_in_idle",   8'h00, 3'd0, 1'b0, 1'b0);
    apply(8'hFF, 1'b0, 1'b0); check("ptr_after_drop", 8'h04, 3'd2, 1'b1, 1'b0);
    apply(8'hFF, 1'b1, 1'b1); check("ack_2",          8'h00, 3'd0, 1'b0, 1'b0);

    // ---- asynchronous reset in the middle of BUSY
    apply(8'hFF, 1'b0, 1'b0); check("pre_rst_grant",  8'h02, 3'd1, 1'b1, 1'b0);
    apply(8'hFF, 1'b1, 1'b0); check("pre_rst_busy",   8'h02, 3'd1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(8'hFF, 1'b0, 1'b0); check("post_rst_ptr",   8'h80, 3'd7, 1'b1, 1'b0);
    apply(8'hFF, 1'b1, 1'b1); check("post_rst_ack",   8'h00, 3'd0, 1'b0, 1'b0);
    // ptr is now 6

`ifdef LOD_ARB_TIMEOUT_EN
    // ---- watchdog: err 4 cycles after BUSY entry, then re-grant
    apply(8'h30, 1'b0, 1'b0); check("to_grant",  8'h20, 3'd5, 1'b1, 1'b0);
    apply(8'h30, 1'b1, 1'b0); check("to_busy0",  8'h20, 3'd5, 1'b0, 1'b0);
    for (int i = 1; i < TIMEOUT; i++) begin
      apply(8'h30, 1'b0, 1'b0);
      check($sformatf("to_busy%0d", i), 8'h20, 3'd5, 1'b0, 1'b0);
    end
    apply(8'h30, 1'b0, 1'b0); check("to_err",    8'h00, 3'd0, 1'b0, 1'b1);
    apply(8'h30, 1'b0, 1'b0); check("to_regrant", 8'h10, 3'd4, 1'b1, 1'b0);
`else
    // ---- without the watchdog BUSY waits for done indefinitely
    apply(8'h30, 1'b0, 1'b0); check("wait_grant", 8'h20, 3'd5, 1'b1, 1'b0);
    apply(8'h30, 1'b1, 1'b0); check("wait_busy",  8'h20, 3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(8'h30, 1'b0, 1'b0);
      check($sformatf("wait_hold%0d", i), 8'h20, 3'd5, 1'b0, 1'b0);
    end
    apply(8'h30, 1'b0, 1'b1); check("wait_done",  8'h00, 3'd0, 1'b0, 1'b0);
    apply(8'h30, 1'b0, 1'b0); check("wait_next",  8'h10, 3'd4, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
